kbd_scan_ctrl: RTL and testbench
================================

# kbd_scan_ctrl

PS/2 scan-code controller sitting directly behind the PS/2 keyboard receiver's byte FIFO. It sequences the receiver's `ready`/`nextdata_n` pop handshake one byte at a time. It decodes the E0 (extended) and F0 (break) prefixes, and tracks the single most recent key. It reports clean press/release events and a press counter to downstream display and lookup logic.

## Interface
- `CNT_W`, default 8: width of the press counter.

- `clk` in 1: system clock; all state updates on the rising edge.
- `clrn` in 1: asynchronous, active-low reset.
- `ready` in 1: receiver FIFO non-empty; `data` is valid while high.
- `data` in 8: byte at the receiver FIFO head.
- `overflow` in 1: receiver overflow flag, level.
- `nextdata_n` out 1: active-low pop strobe to the receiver; low for exactly one cycle per consumed byte.
- `key_code` out 8: scan code of the current or last key.
- `key_ext` out 1: `key_code` was E0-prefixed.
- `key_down` out 1: the tracked key is currently held.
- `key_valid` out 1: one-cycle pulse on each new (non-repeat) make event.
- `key_release` out 1: one-cycle pulse when the tracked key is released.
- `press_cnt` out `CNT_W`: count of new make events; wraps modulo 2^`CNT_W`.
- `err` out 1: sticky error flag.

## Operation
- Reset values: `nextdata_n`=1, `key_code`=0x00, `key_ext`=0, `key_down`=0, `key_valid`=0, `key_release`=0, `press_cnt`=0, `err`=0. Internally: state=IDLE, `ext_pend`=0, `brk_pend`=0, byte register=0.
- States and transitions:
  - IDLE→POP when `ready`=1. On this transition `data` is captured into the byte register and `nextdata_n` is driven 0.
  - POP→WAIT unconditionally. `nextdata_n` returns to 1, and the decode result is registered.
  - WAIT→IDLE unconditionally. This cycle is the receiver's pointer-update slack.
- Decode of the captured byte b, performed in POP:
  - b=0xE0: set `ext_pend`. No event.
  - b=0xF0: if `brk_pend` is already 1, set `err`. In either case set `brk_pend`. No event.
  - b=0x00 or 0xFF (keyboard error codes): set `err`, clear both pend flags. No event.
  - Other b with `brk_pend`=1 (break):
    - If `key_down`=1, b=`key_code` and `ext_pend`=`key_ext`: `key_down`←0 and pulse `key_release`.
    - Otherwise the break is ignored and `key_code`/`key_ext` are unchanged.
    - Clear both pend flags.
  - Other b with `brk_pend`=0 (make):
    - If `key_down`=1, b=`key_code` and `ext_pend`=`key_ext`: typematic repeat. No pulse, no count.
    - Otherwise: `key_code`←b, `key_ext`←`ext_pend`, `key_down`←1, pulse `key_valid`, `press_cnt`←`press_cnt`+1 (wrapping).
    - Clear both pend flags.
  - The last key wins. A new make while another key is held replaces the tracked key. A later break of the older key is ignored.
- `overflow` is sampled every cycle in any state; overflow=1 sets `err`.
- `err` is cleared only by `clrn`.
- Reset mid-operation: `clrn` low forces every register to its reset value immediately, including `nextdata_n`=1 during POP. A byte whose pop was cut short is re-read after reset if the receiver still presents it.

## Timing
- Edge T: IDLE samples `ready`=1. During T..T+1 the state is POP and `nextdata_n`=0.
- Edge T+1: the state moves to WAIT, `nextdata_n`=1, and the decoded outputs update. `key_valid`/`key_release` are high for that single cycle only.
- Edge T+2: the state returns to IDLE and the pulses drop.
- Edge T+3: the earliest sample of the next byte.
- Throughput: one byte per 3 cycles. Latency from byte capture to event visible: 1 cycle.
- `key_valid` and `key_release` are never high together. Each pulse is at most one cycle per consumed byte.
- `ready` is ignored outside IDLE, and `data` is not sampled outside the IDLE→POP edge.
- `press_cnt` and `key_code` update on the same edge as `key_valid`.

## Test plan
- Reset: hold `clrn`=0 with `ready`=1 → all outputs at reset values, `nextdata_n`=1, no pop. Release → the first pop occurs 1 edge after release.
- Single press:
  - FIFO holds 0x1C → `nextdata_n` low exactly 1 cycle.
  - On the next edge: `key_valid`=1 for 1 cycle, `key_code`=0x1C, `key_ext`=0, `key_down`=1, `press_cnt`=1.
  - The next `ready` sample is 3 cycles after the previous one.
- Typematic and release: 0x1C,0x1C,0x1C,0xF0,0x1C → a single `key_valid`, `press_cnt`=1. Then one `key_release` pulse after the final byte, with `key_down`=0 and `key_code` still 0x1C.
- Extended keys:
  - 0xE0,0x75 → `key_code`=0x75, `key_ext`=1.
  - Then 0xF0,0x75 (non-extended break) → ignored, `key_down` stays 1.
  - Then 0xE0,0xF0,0x75 → `key_release` pulse.
- Counter wrap: with `CNT_W`=2, send 5 distinct makes (0x15,0x1D,0x24,0x2D,0x2C) → `press_cnt` sequence 1,2,3,0,1. Last-key-wins: after these, 0xF0,0x15 produces no `key_release`.
- Errors and reset mid-pop:
  - 0xF0,0xF0 → `err`=1, remaining sticky through further valid traffic.
  - A fresh reset, then a one-cycle `overflow`=1 pulse → `err`=1.
  - Byte 0x00 → `err`=1, no event.
  - `clrn` pulsed low during POP → `nextdata_n`=1 immediately and all outputs at reset values.

Source files
------------

// File: rtl/kbd_scan_ctrl.sv
// kbd_scan_ctrl: pops bytes from a PS/2 receiver FIFO one at a time,
// decodes E0/F0 prefixes, tracks the most recent key and reports
// make/release events, a press counter and a sticky error flag.
module kbd_scan_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ready,
  input  logic [7:0]       data,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_down,
  output logic             key_valid,
  output logic             key_release,
  output logic [CNT_W-1:0] press_cnt,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             ext_pend_q, ext_pend_d;
  logic             brk_pend_q, brk_pend_d;
  logic             nextdata_n_q, nextdata_n_d;
  logic [7:0]       key_code_q, key_code_d;
  logic             key_ext_q, key_ext_d;
  logic             key_down_q, key_down_d;
  logic             key_valid_q, key_valid_d;
  logic             key_release_q, key_release_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic             err_q, err_d;

  // Captured byte names the key currently held (same code and same prefix).
  logic same_key;
  assign same_key = key_down_q && (byte_q == key_code_q) && (ext_pend_q == key_ext_q);

  // State register and all decoded outputs; clrn clears everything at once.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q       <= IDLE;
      byte_q        <= 8'h00;
      ext_pend_q    <= 1'b0;
      brk_pend_q    <= 1'b0;
      nextdata_n_q  <= 1'b1;
      key_code_q    <= 8'h00;
      key_ext_q     <= 1'b0;
      key_down_q    <= 1'b0;
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
      press_cnt_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_q        <= byte_d;
      ext_pend_q    <= ext_pend_d;
      brk_pend_q    <= brk_pend_d;
      nextdata_n_q  <= nextdata_n_d;
      key_code_q    <= key_code_d;
      key_ext_q     <= key_ext_d;
      key_down_q    <= key_down_d;
      key_valid_q   <= key_valid_d;
      key_release_q <= key_release_d;
      press_cnt_q   <= press_cnt_d;
      err_q         <= err_d;
    end
  end

  // Next-state: pop handshake sequencing and scan-code decode in POP.
  always_comb begin
    state_d       = state_q;
    byte_d        = byte_q;
    ext_pend_d    = ext_pend_q;
    brk_pend_d    = brk_pend_q;
    nextdata_n_d  = 1'b1;
    key_code_d    = key_code_q;
    key_ext_d     = key_ext_q;
    key_down_d    = key_down_q;
    key_valid_d   = 1'b0;
    key_release_d = 1'b0;
    press_cnt_d   = press_cnt_q;
    err_d         = err_q | overflow;

    case (state_q)
      IDLE: begin
        if (ready) begin
          byte_d       = data;
          nextdata_n_d = 1'b0;
          state_d      = POP;
        end
      end
      POP: begin
        state_d = WAIT;
        if (byte_q == 8'hE0) begin
          ext_pend_d = 1'b1;
        end else if (byte_q == 8'hF0) begin
          // A second break prefix in a row is a protocol error.
          if (brk_pend_q) err_d = 1'b1;
          brk_pend_d = 1'b1;
        end else if (byte_q == 8'h00 || byte_q == 8'hFF) begin
          err_d      = 1'b1;
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end else begin
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
          if (brk_pend_q) begin
            // Only a break of the tracked key counts; older keys are ignored.
            if (same_key) begin
              key_down_d    = 1'b0;
              key_release_d = 1'b1;
            end
          end else if (!same_key) begin
            // New make (typematic repeats of the held key fall through).
            key_code_d  = byte_q;
            key_ext_d   = ext_pend_q;
            key_down_d  = 1'b1;
            key_valid_d = 1'b1;
            press_cnt_d = press_cnt_q + CNT_W'(1);
          end
        end
      end
      WAIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign nextdata_n  = nextdata_n_q;
  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign key_down    = key_down_q;
  assign key_valid   = key_valid_q;
  assign key_release = key_release_q;
  assign press_cnt   = press_cnt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Directed bench for kbd_scan_ctrl: a table of bytes with hand-computed
// expected outputs plus hand-written reset / overflow / mid-pop sequences.
// A second instance with a 2-bit counter checks counter wrap-around.
module tb_kbd_scan_ctrl;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] data = 8'h00;
  logic       overflow = 1'b0;

  logic       nextdata_n, key_ext, key_down, key_valid, key_release, err;
  logic [7:0] key_code;
  logic [7:0] press_cnt;

  logic       nextdata_n_2, key_ext_2, key_down_2, key_valid_2, key_release_2, err_2;
  logic [7:0] key_code_2;
  logic [1:0] press_cnt_2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  kbd_scan_ctrl u_dut8 (
    .clk(clk), .clrn(clrn), .ready(ready), .data(data), .overflow(overflow),
    .nextdata_n(nextdata_n), .key_code(key_code), .key_ext(key_ext),
    .key_down(key_down), .key_valid(key_valid), .key_release(key_release),
    .press_cnt(press_cnt), .err(err)
  );

  kbd_scan_ctrl #(.CNT_W(2)) u_dut2 (
    .clk(clk), .clrn(clrn), .ready(ready), .data(data), .overflow(overflow),
    .nextdata_n(nextdata_n_2), .key_code(key_code_2), .key_ext(key_ext_2),
    .key_down(key_down_2), .key_valid(key_valid_2), .key_release(key_release_2),
    .press_cnt(press_cnt_2), .err(err_2)
  );

  typedef struct {
    bit         rst;   // reset both instances before this byte
    logic [7:0] b;
    logic       v;
    logic       r;
    logic [7:0] code;
    logic       ext;
    logic       down;
    int         cnt;
    logic       e;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, logic [7:0] b, logic v, logic r, logic [7:0] code,
                              logic ext, logic down, int cnt, logic e);
    vec_t t;
    t.rst = rst; t.b = b; t.v = v; t.r = r; t.code = code;
    t.ext = ext; t.down = down; t.cnt = cnt; t.e = e;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_state(string tag, logic v, logic r, logic [7:0] code, logic ext,
                             logic down, int cnt, logic e);
    check({tag, ".key_valid"}, 32'(key_valid), 32'(v));
    check({tag, ".key_release"}, 32'(key_release), 32'(r));
    check({tag, ".key_code"}, 32'(key_code), 32'(code));
    check({tag, ".key_ext"}, 32'(key_ext), 32'(ext));
    check({tag, ".key_down"}, 32'(key_down), 32'(down));
    check({tag, ".press_cnt"}, 32'(press_cnt), 32'(cnt % 256));
    check({tag, ".press_cnt_w2"}, 32'(press_cnt_2), 32'(cnt % 4));
    check({tag, ".err"}, 32'(err), 32'(e));
  endtask

  task automatic do_reset();
    ready = 1'b0;
    clrn  = 1'b0;
    @(posedge clk); #1;
    clrn  = 1'b1;
  endtask

  // One byte through IDLE->POP->WAIT->IDLE, checking each cycle.
  task automatic send_vec(int idx, vec_t t);
    string tag;
    tag = $sformatf("vec%0d", idx);
    ready = 1'b1;
    data  = t.b;
    @(posedge clk); #1;
    check({tag, ".pop_low"}, 32'(nextdata_n), 32'd0);
    ready = 1'b0;
    @(posedge clk); #1;
    check({tag, ".pop_high"}, 32'(nextdata_n), 32'd1);
    check_state(tag, t.v, t.r, t.code, t.ext, t.down, t.cnt, t.e);
    @(posedge clk); #1;
    check({tag, ".valid_drop"}, 32'(key_valid), 32'd0);
    check({tag, ".release_drop"}, 32'(key_release), 32'd0);
    $display("byte %0d: %02h -> valid=%0b release=%0b code=%02h ext=%0b down=%0b cnt=%0d err=%0b",
             idx, t.b, key_valid, key_release, key_code, key_ext, key_down, press_cnt, err);
  endtask

  initial begin
    // Single press, typematic and release
    vecs.push_back(mk(1, 8'h1C, 1, 0, 8'h1C, 0, 1, 1, 0));
    vecs.push_back(mk(0, 8'h1C, 0, 0, 8'h1C, 0, 1, 1, 0));
    vecs.push_back(mk(0, 8'h1C, 0, 0, 8'h1C, 0, 1, 1, 0));
    vecs.push_back(mk(0, 8'hF0, 0, 0, 8'h1C, 0, 1, 1, 0));
    vecs.push_back(mk(0, 8'h1C, 0, 1, 8'h1C, 0, 0, 1, 0));
    // Extended key, non-extended break ignored, extended break
    vecs.push_back(mk(0, 8'hE0, 0, 0, 8'h1C, 0, 0, 1, 0));
    vecs.push_back(mk(0, 8'h75, 1, 0, 8'h75, 1, 1, 2, 0));
    vecs.push_back(mk(0, 8'hF0, 0, 0, 8'h75, 1, 1, 2, 0));
    vecs.push_back(mk(0, 8'h75, 0, 0, 8'h75, 1, 1, 2, 0));
    vecs.push_back(mk(0, 8'hE0, 0, 0, 8'h75, 1, 1, 2, 0));
    vecs.push_back(mk(0, 8'hF0, 0, 0, 8'h75, 1, 1, 2, 0));
    vecs.push_back(mk(0, 8'h75, 0, 1, 8'h75, 1, 0, 2, 0));
    // Counter wrap and last-key-wins
    vecs.push_back(mk(1, 8'h15, 1, 0, 8'h15, 0, 1, 1, 0));
    vecs.push_back(mk(0, 8'h1D, 1, 0, 8'h1D, 0, 1, 2, 0));
    vecs.push_back(mk(0, 8'h24, 1, 0, 8'h24, 0, 1, 3, 0));
    vecs.push_back(mk(0, 8'h2D, 1, 0, 8'h2D, 0, 1, 4, 0));
    vecs.push_back(mk(0, 8'h2C, 1, 0, 8'h2C, 0, 1, 5, 0));
    vecs.push_back(mk(0, 8'hF0, 0, 0, 8'h2C, 0, 1, 5, 0));
    vecs.push_back(mk(0, 8'h15, 0, 0, 8'h2C, 0, 1, 5, 0));
    // Double break prefix: sticky error, following byte is a (stray) break
    vecs.push_back(mk(1, 8'hF0, 0, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'hF0, 0, 0, 8'h00, 0, 0, 0, 1));
    vecs.push_back(mk(0, 8'h1C, 0, 0, 8'h00, 0, 0, 0, 1));
    vecs.push_back(mk(0, 8'h1C, 1, 0, 8'h1C, 0, 1, 1, 1));
    vecs.push_back(mk(0, 8'hF0, 0, 0, 8'h1C, 0, 1, 1, 1));
    vecs.push_back(mk(0, 8'h1C, 0, 1, 8'h1C, 0, 0, 1, 1));
    // Error code byte clears pending prefixes
    vecs.push_back(mk(1, 8'hE0, 0, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1));
    vecs.push_back(mk(0, 8'h1C, 1, 0, 8'h1C, 0, 1, 1, 1));
    vecs.push_back(mk(0, 8'hFF, 0, 0, 8'h1C, 0, 1, 1, 1));

    // Reset held with ready=1: no pop, reset values
    clrn = 1'b0;
    ready = 1'b1;
    data = 8'h1C;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst.nextdata_n", 32'(nextdata_n), 32'd1);
      check_state("rst", 0, 0, 8'h00, 0, 0, 0, 0);
    end
    $display("reset held: nextdata_n=%0b code=%02h cnt=%0d", nextdata_n, key_code, press_cnt);

    // Release with ready held high: pop 1 edge later, then one per 3 cycles
    clrn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("thru%0d.nextdata_n", i), 32'(nextdata_n), (i % 3 == 0) ? 32'd0 : 32'd1);
      check($sformatf("thru%0d.key_valid", i), 32'(key_valid), (i == 1) ? 32'd1 : 32'd0);
    end
    ready = 1'b0;
    check("thru.press_cnt", 32'(press_cnt), 32'd1);
    $display("throughput: two pops of 1C, cnt=%0d", press_cnt);

    // Table-driven vectors
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      send_vec(i, vecs[i]);
    end

    // Single-cycle overflow pulse sets sticky err
    do_reset();
    check("ovf.err_before", 32'(err), 32'd0);
    overflow = 1'b1;
    @(posedge clk); #1;
    overflow = 1'b0;
    check("ovf.err_set", 32'(err), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("ovf.err_sticky", 32'(err), 32'd1);
    $display("overflow pulse: err=%0b", err);

    // Reset asserted during POP
    do_reset();
    send_vec(100, mk(0, 8'h1C, 1, 0, 8'h1C, 0, 1, 1, 0));
    ready = 1'b1;
    data = 8'h2C;
    @(posedge clk); #1;
    check("midpop.pop_low", 32'(nextdata_n), 32'd0);
    clrn = 1'b0;
    #1;
    check("midpop.nextdata_n", 32'(nextdata_n), 32'd1);
    check_state("midpop", 0, 0, 8'h00, 0, 0, 0, 0);
    @(posedge clk); #1;
    clrn = 1'b1;
    @(posedge clk); #1;
    check("midpop.repop", 32'(nextdata_n), 32'd0);
    ready = 1'b0;
    @(posedge clk); #1;
    check_state("midpop.reread", 1, 0, 8'h2C, 0, 1, 1, 0);
    $display("mid-pop reset: re-read code=%02h cnt=%0d", key_code, press_cnt);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
